// File: rtl/dest_queue.sv
// dest_queue: per-destination output stage.
// Round-robin arbitration over the per-source word bus, one accepted word
// per cycle, buffered in a first-word-fall-through FIFO toward the port.
module dest_queue #(
  parameter int PORT_NUB   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEST       = 0,
  parameter int DEPTH      = 16
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [PORT_NUB*(2*$clog2(PORT_NUB)+DATA_WIDTH)-1:0] port_in,
  input  logic [PORT_NUB-1:0]                                 port_vaild,
  output logic [PORT_NUB-1:0]                                 port_ready,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [$clog2(PORT_NUB)-1:0]                         out_tx,
  output logic [DATA_WIDTH-1:0]                               out_data,
  output logic [$clog2(DEPTH):0]                              count,
  output logic                                                full,
  output logic                                                rx_err
);

  localparam int WIDTH_SEL  = $clog2(PORT_NUB);
  localparam int WIDTH_PORT = 2*WIDTH_SEL + DATA_WIDTH;
  localparam int ENTRY_W    = WIDTH_SEL + DATA_WIDTH;
  localparam int PTR_W      = $clog2(DEPTH);

  localparam logic [WIDTH_SEL-1:0] DEST_SEL  = WIDTH_SEL'(DEST);
  localparam logic [WIDTH_SEL-1:0] LAST_SRC  = WIDTH_SEL'(PORT_NUB - 1);
  localparam logic [PTR_W:0]       DEPTH_CNT = (PTR_W+1)'(DEPTH);

  // Per-source fields unpacked from the flattened bus
  logic [WIDTH_SEL-1:0] src_rx    [PORT_NUB];
  logic [ENTRY_W-1:0]   src_entry [PORT_NUB];
  logic [PORT_NUB-1:0]  eligible;
  logic [PORT_NUB-1:0]  misrouted;

  // State
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W:0]       count_reg;
  logic [PTR_W:0]       count_next;
  logic [WIDTH_SEL-1:0] rr_reg;
  logic [WIDTH_SEL-1:0] rr_next;
  logic                 rx_err_reg;

  // Arbitration results
  logic                 found;
  logic [WIDTH_SEL-1:0] winner;
  logic                 space;
  logic                 push;
  logic                 pop;
  int                   scan_idx;
  logic [WIDTH_SEL-1:0] scan_sel;
  logic [ENTRY_W-1:0]   head_entry;

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUB; gi++) begin : g_src
      // Word layout is {rx_ports, tx_ports, data}; only {tx, data} is stored
      assign src_entry[gi] = port_in[gi*WIDTH_PORT +: ENTRY_W];
      assign src_rx[gi]    = port_in[gi*WIDTH_PORT + ENTRY_W +: WIDTH_SEL];
      assign eligible[gi]  = port_vaild[gi] && (src_rx[gi] == DEST_SEL);
      assign misrouted[gi] = port_vaild[gi] && (src_rx[gi] != DEST_SEL);
    end
  endgenerate

  assign pop   = out_valid & out_ready;
  assign space = (count_reg < DEPTH_CNT) | pop;

  // Round-robin scan starting at rr_reg; first eligible source wins
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    scan_sel = '0;
    for (int k = 0; k < PORT_NUB; k++) begin
      scan_idx = int'(rr_reg) + k;
      if (scan_idx >= PORT_NUB) begin
        scan_idx = scan_idx - PORT_NUB;
      end
      scan_sel = WIDTH_SEL'(scan_idx);
      if (!found && eligible[scan_sel]) begin
        found  = 1'b1;
        winner = scan_sel;
      end
    end
  end

  // Grant goes only to the winner, only when the FIFO can take the word
  always_comb begin
    port_ready = '0;
    if (rst_n && found && space) begin
      port_ready[winner] = 1'b1;
    end
  end

  assign push = |(port_ready & port_vaild);

  // Next round-robin start is the source after the one just accepted
  always_comb begin
    rr_next = rr_reg;
    if (push) begin
      rr_next = (winner == LAST_SRC) ? '0 : winner + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leave it unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= src_entry[winner];
    end
  end

  // Pointers, occupancy, arbitration pointer and sticky error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      rr_reg     <= '0;
      rx_err_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      rr_reg    <= rr_next;
      if (|misrouted) begin
        rx_err_reg <= 1'b1;
      end
    end
  end

  // Head of FIFO falls through directly to the outputs
  assign head_entry = mem[rd_ptr_reg];
  assign out_tx     = head_entry[ENTRY_W-1 -: WIDTH_SEL];
  assign out_data   = head_entry[DATA_WIDTH-1:0];
  assign out_valid  = (count_reg != '0);
  assign count      = count_reg;
  assign full       = (count_reg == DEPTH_CNT);
  assign rx_err     = rx_err_reg;

endmodule

// File: tb/tb_dest_queue.sv
// tb_dest_queue: randomized and directed stimulus for dest_queue with a
// queue-based reference model; a separate monitor checks every popped word.
module tb_dest_queue;

  localparam int NP    = 4;
  localparam int DW    = 16;
  localparam int DEST  = 2;
  localparam int DEPTH = 4;
  localparam int WS    = 2;
  localparam int WP    = 2*WS + DW;

  logic               clk;
  logic               rst_n;
  logic [NP*WP-1:0]   port_in;
  logic [NP-1:0]      port_vaild;
  logic [NP-1:0]      port_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WS-1:0]      out_tx;
  logic [DW-1:0]      out_data;
  logic [2:0]         count;
  logic               full;
  logic               rx_err;

  dest_queue #(
    .PORT_NUB(NP), .DATA_WIDTH(DW), .DEST(DEST), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .port_in(port_in), .port_vaild(port_vaild),
    .port_ready(port_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_tx(out_tx), .out_data(out_data), .count(count), .full(full),
    .rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source-side stimulus state
  logic [NP-1:0] src_v;
  logic [WS-1:0] src_rx [NP];
  logic [WS-1:0] src_tx [NP];
  logic [DW-1:0] src_d  [NP];
  logic          ordy;

  // Reference model
  logic [WS+DW-1:0] exp_q [$];
  int               mcnt;
  int               rr;
  logic             merr;

  int n_checks;
  int n_fail;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      port_in[i*WP +: WP] = {src_rx[i], src_tx[i], src_d[i]};
    end
    port_vaild = src_v;
    out_ready  = ordy;
  endtask

  // Predict this cycle's grant from the rules, compare, then advance the model
  task automatic model_cycle();
    logic [NP-1:0] er;
    int  win;
    bit  sp, pp, ph;
    chk("count", 32'(count), 32'(mcnt));
    chk("full", 32'(full), 32'(mcnt == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
    chk("rx_err", 32'(rx_err), 32'(merr));
    if (!rst_n) begin
      chk("ready_in_reset", 32'(port_ready), 32'd0);
      exp_q.delete();
      mcnt = 0;
      rr   = 0;
      merr = 1'b0;
      return;
    end
    win = -1;
    for (int k = 0; k < NP; k++) begin
      int idx;
      idx = (rr + k) % NP;
      if (win < 0 && src_v[idx] && src_rx[idx] == WS'(DEST)) win = idx;
    end
    pp = (mcnt != 0) && ordy;
    sp = (mcnt < DEPTH) || pp;
    er = '0;
    ph = (win >= 0) && sp;
    if (ph) er[win] = 1'b1;
    chk("port_ready", 32'(port_ready), 32'(er));
    for (int i = 0; i < NP; i++) begin
      if (src_v[i] && src_rx[i] != WS'(DEST)) merr = 1'b1;
    end
    if (ph) begin
      exp_q.push_back({src_tx[win], src_d[win]});
      rr = (win + 1) % NP;
      src_v[win] = 1'b0;
    end
    mcnt = mcnt + (ph ? 1 : 0) - (pp ? 1 : 0);
  endtask

  // One clock: drive at posedge+1, check at negedge+1, return at posedge+1
  task automatic step();
    apply();
    @(negedge clk);
    #1;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_src(input int i, input logic [WS-1:0] rx, input logic [DW-1:0] d);
    src_v[i]  = 1'b1;
    src_rx[i] = rx;
    src_tx[i] = WS'(i);
    src_d[i]  = d;
  endtask

  // Monitor: every word the DUT hands downstream must match the model's order
  always @(negedge clk) begin
    logic [WS+DW-1:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got tx=%0h data=%0h expected no word at %0t", out_tx, out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_tx", 32'(out_tx), 32'(e[WS+DW-1:DW]));
        chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
        $display("pop tx=%0d data=%04h count=%0d", out_tx, out_data, count);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mcnt     = 0;
    rr       = 0;
    merr     = 1'b0;
    src_v    = '0;
    ordy     = 1'b0;
    for (int i = 0; i < NP; i++) begin
      src_rx[i] = WS'(DEST);
      src_tx[i] = WS'(i);
      src_d[i]  = '0;
    end
    port_in = '0;
    rst_n   = 1'b0;
    apply();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset
    run(2);

    // All four sources, downstream stalled: fill in rotation order
    for (int i = 0; i < NP; i++) set_src(i, WS'(DEST), 16'hA000 + 16'(i));
    run(4);
    set_src(1, WS'(DEST), 16'h1111);
    run(1);
    // Full with simultaneous pop accepts one word
    ordy = 1'b1;
    run(1);
    run(6);

    // Single push into empty FIFO: no bypass
    set_src(3, WS'(DEST), 16'hBEEF);
    run(3);

    // Misrouted word on source 0 is never granted; others still served
    set_src(0, 2'd1, 16'hDEAD);
    set_src(2, WS'(DEST), 16'h2222);
    run(3);
    set_src(1, WS'(DEST), 16'h3333);
    run(3);
    src_v[0] = 1'b0;
    run(2);

    // Reset mid-operation with three words held
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) set_src(i, WS'(DEST), 16'hC000 + 16'(i));
    run(3);
    set_src(3, WS'(DEST), 16'h4444);
    set_src(1, WS'(DEST), 16'h5555);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(3);
    ordy = 1'b1;
    run(4);

    // Randomized traffic; misrouted words may be withdrawn since they never win
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!src_v[i] && ($urandom_range(0, 1) == 1)) begin
          set_src(i, ($urandom_range(0, 15) == 0) ? WS'($urandom_range(0, 1)) : WS'(DEST),
                  DW'($urandom));
        end else if (src_v[i] && src_rx[i] != WS'(DEST) && $urandom_range(0, 3) == 0) begin
          src_v[i] = 1'b0;
        end
      end
      ordy = (c % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (c == 250) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    // Drain
    src_v = '0;
    ordy  = 1'b1;
    run(DEPTH + 3);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dest_queue.md
Name: dest_queue

Overview:
- Per-destination output stage; one instance sits directly downstream of each destination filter.
- Consumes the filter's flattened per-source word bus and per-source valid vector.
- Round-robin arbitrates among concurrently valid sources, accepting one word per cycle with per-source backpressure.
- Buffers accepted words in a FIFO and presents them on a valid/ready output toward the destination port.

Parameters:
- PORT_NUB, `PORT_NUB_TOTAL, number of source ports (>=2).
- DATA_WIDTH, `DATA_WIDTH, payload width.
- DEST, 0, destination port index this instance serves.
- DEPTH, 16, FIFO entries; power of two, >=2.
- Derived: WIDTH_SEL = $clog2(PORT_NUB); WIDTH_PORT = 2*WIDTH_SEL+DATA_WIDTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- port_in  input  PORT_NUB*WIDTH_PORT  source i word at [(i+1)*WIDTH_PORT-1 : i*WIDTH_PORT], format {rx_ports, tx_ports, data}.
- port_vaild  input  PORT_NUB  per-source valid.
- port_ready  output  PORT_NUB  one-hot (or zero) grant/accept back to sources.
- out_valid  output  1  head-of-FIFO word available.
- out_ready  input  1  downstream accepts head word.
- out_tx  output  WIDTH_SEL  source port of head word.
- out_data  output  DATA_WIDTH  payload of head word.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count==DEPTH.
- rx_err  output  1  sticky flag: a valid word arrived with rx_ports!=DEST.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rd_ptr, wr_ptr, count, rr_ptr and rx_err are cleared to 0.
  - out_valid=0, full=0.
  - FIFO contents are discarded, including on reset mid-operation.
  - port_ready is forced to 0 while rst_n=0.
  - out_tx and out_data are don't-care while out_valid=0.
- Eligibility: source i is eligible when port_vaild[i]=1 and rx_ports==DEST.
  - A valid word with rx_ports!=DEST is never granted and sets rx_err on the next edge. rx_err stays set until reset.
- Pop: pop = out_valid & out_ready.
- Space: space = (count<DEPTH) | pop. Full with a simultaneous pop still accepts one word.
- Arbitration (combinational, same cycle):
  - Scan sources rr_ptr, rr_ptr+1, ... mod PORT_NUB; the first eligible source is the winner.
  - port_ready[winner]=space; all other bits are 0.
  - No eligible source: port_ready=0.
  - A combinational path out_ready -> port_ready is permitted.
- Push: push = |(port_ready & port_vaild).
  - On push, write {tx_ports,data} of the winner at wr_ptr; wr_ptr increments mod DEPTH.
  - rr_ptr <= (winner+1) mod PORT_NUB.
  - Without a push, rr_ptr holds, including when the winner is blocked by a full FIFO.
- Sources not granted must hold their word; this block does not latch them.
- FIFO is first-word-fall-through:
  - out_valid = (count!=0).
  - out_tx/out_data are the entry at rd_ptr.
  - On pop, rd_ptr increments mod DEPTH.
- Latency: a word accepted at edge N is visible on out_* after edge N (one cycle).
  - Push into an empty FIFO with out_ready=1 does not bypass; out_valid rises the cycle after accept.
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - Never exceeds DEPTH and never underflows.
- Order: words leave in acceptance order. Per-source order is preserved.
- Fairness: with all sources continuously eligible and space available, grants rotate 0,1,...,PORT_NUB-1 with no source starved.

Test Plan:
- Bench configuration: PORT_NUB=4, DATA_WIDTH=16, DEST=2, DEPTH=4.
- Reset then idle -> out_valid=0, count=0, full=0, port_ready=4'b0000, rx_err=0.
- Sources 0..3 all valid with rx=2, data 0xA000+i, out_ready=0 -> grants 0,1,2,3 on consecutive cycles. count reaches 4 and full=1. Next cycle port_ready=0 and rr_ptr=0 held.
- Full FIFO, out_ready=1, source 1 valid with data 0x1111 -> pop of 0xA000 and push of 0x1111 in the same cycle; count stays 4. Subsequent drain order is 0xA001,0xA002,0xA003,0x1111.
- Empty FIFO, single push of source 3 (tx=3, data 0xBEEF) with out_ready=1 -> out_valid=0 in the accept cycle. Next cycle out_valid=1, out_tx=3, out_data=0xBEEF, popped that cycle, count returns to 0.
- Source 0 valid with rx=1 -> never granted, rx_err=1 the next cycle and stays set. Other sources are still served normally.
- Reset asserted with count=3 -> after the edge, count=0, out_valid=0, rr_ptr=0. The first grant after reset goes to the lowest eligible source.
